ib_fetch_ctrl: RTL and testbench
================================

IB_FETCH_CTRL -- requirements
Module: ib_fetch_ctrl

Interface
REQ-001 Parameter AWIDTH, default 6, SHALL set the instruction-address width.
REQ-002 Parameter DWIDTH, default 32, SHALL set the instruction-word width.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be an asynchronous, active-low reset.
REQ-005 Port start, input, 1: begin or resume fetching from IDLE or HALTED.
REQ-006 Port stall, input, 1: hold off the next fetch (level).
REQ-007 Port halt, input, 1: stop fetching after the current fetch (level).
REQ-008 Port branch_en, input, 1: apply a relative redirect at the next PC update.
REQ-009 Port branch_off, input, AWIDTH: two's-complement branch offset.
REQ-010 Port jump_en, input, 1: apply an absolute redirect at the next PC update.
REQ-011 Port jump_addr, input, AWIDTH: absolute jump target.
REQ-012 Port mem_req, output, 1: fetch request to instruction memory.
REQ-013 Port mem_addr, output, AWIDTH: fetch address; always equals pc.
REQ-014 Port mem_ack, input, 1: memory returns instr_in this cycle.
REQ-015 Port instr_in, input, DWIDTH: fetched instruction word.
REQ-016 Port instr_out, output, DWIDTH: registered last fetched word.
REQ-017 Port instr_valid, output, 1: one-cycle pulse per fetched word.
REQ-018 Port pc_out, output, AWIDTH: current program counter.
REQ-019 Port redir_taken, output, 1: one-cycle pulse when a branch or jump is consumed.
REQ-020 Port busy, output, 1: high in REQ or STALL.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, REQ, STALL, HALTED.
REQ-022 In IDLE or HALTED, start=1 SHALL move to REQ (stall=0) or STALL (stall=1) next cycle; pc is unchanged.
REQ-023 mem_req SHALL be 1 only in REQ.
REQ-024 Once raised, mem_req SHALL remain high until mem_ack=1.
REQ-025 mem_addr SHALL be stable while mem_req is high.
REQ-026 mem_ack outside REQ SHALL be ignored.
REQ-027 A REQ cycle with mem_ack=1 (accept cycle) SHALL trigger all of the following next cycle:
- instr_out <= instr_in;
- instr_valid = 1 for one cycle;
- pc <= next_pc.
REQ-028 next_pc priority SHALL be:
- jump_en: jump_addr;
- else branch_en: pc + branch_off;
- else pc + 1.
REQ-029 Additions SHALL be modulo 2^AWIDTH with no carry out. Example: pc 63 + 1 = 0; pc 2 + offset 6'b111110 = 0.
REQ-030 branch_en, jump_en, stall and halt SHALL be sampled only in accept cycles, or in STALL for stall.
REQ-031 redir_taken SHALL pulse the cycle after an accept cycle in which jump_en or branch_en was 1.
REQ-032 After an accept cycle, the next state SHALL be:
- halt=1: HALTED (halt wins over stall);
- else stall=1: STALL;
- else REQ.
REQ-033 A REQ-to-REQ transition SHALL sustain one fetch per cycle when mem_ack is held high.
REQ-034 In STALL, stall=0 SHALL move to REQ next cycle.
REQ-035 start SHALL be ignored in REQ and STALL.

Reset
REQ-036 On rst_n=0, asynchronously and regardless of state or outstanding request, the block SHALL set:
- state = IDLE;
- pc = 0;
- mem_req = 0, instr_out = 0, instr_valid = 0, redir_taken = 0.
REQ-037 A fetch interrupted by reset SHALL be abandoned; a late mem_ack after reset SHALL be ignored.

Structure
REQ-038 Package ib_pkg SHALL hold the following:
- the state enum type ib_fetch_state_t;
- the AWIDTH and DWIDTH defaults;
- constant IB_INC_ONE.
REQ-039 Sub-module ib_pc_adder SHALL compute pc + inc (AWIDTH, combinational).
REQ-040 The inc input of ib_pc_adder SHALL be driven by branch_en ? branch_off : IB_INC_ONE; jump bypasses the adder via a mux.

Verification (AWIDTH=6)
REQ-041 Stream: reset, start, mem_ack tied 1 -> instr_valid high every cycle, mem_addr 0,1,2,3.
REQ-042 Wrap: jump to 62, ack twice -> mem_addr 62, 63, then 0.
REQ-043 Backward branch: at pc=10, branch_off=-4 with ack -> next pc 6, redir_taken pulse; jump_en and branch_en together -> jump_addr wins.
REQ-044 Wait states: mem_ack delayed 3 cycles with stall pulsed meanwhile -> mem_req and mem_addr held, stall ignored until accept; halt+stall on accept -> HALTED, busy=0.
REQ-045 Reset mid-fetch: rst_n low while mem_req=1 -> all outputs at reset values immediately; ack after release produces no instr_valid.

Source files
------------

// File: rtl/ib_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package ib_pkg;

    localparam int unsigned IB_AWIDTH  = 6;
    localparam int unsigned IB_DWIDTH  = 32;
    localparam int unsigned IB_INC_ONE = 1;

    typedef enum logic [1:0] {
        IB_IDLE,
        IB_REQ,
        IB_STALL,
        IB_HALTED
    } ib_fetch_state_t;

endpackage

// File: rtl/ib_pc_adder.sv
// Program-counter adder: sum wraps modulo 2^AWIDTH, carry is discarded.
module ib_pc_adder #(
    parameter int unsigned AWIDTH = 6
) (
    input  logic [AWIDTH-1:0] pc,
    input  logic [AWIDTH-1:0] inc,
    output logic [AWIDTH-1:0] sum
);

    assign sum = pc + inc;

endmodule

// File: rtl/ib_fetch_ctrl.sv
// Instruction-fetch controller: issues one fetch per accepted cycle and
// applies jump/branch redirects or sequential increment to the PC.
module ib_fetch_ctrl
    import ib_pkg::*;
#(
    parameter int unsigned AWIDTH = IB_AWIDTH,
    parameter int unsigned DWIDTH = IB_DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              halt,
    input  logic              branch_en,
    input  logic [AWIDTH-1:0] branch_off,
    input  logic              jump_en,
    input  logic [AWIDTH-1:0] jump_addr,
    output logic              mem_req,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DWIDTH-1:0] instr_in,
    output logic [DWIDTH-1:0] instr_out,
    output logic              instr_valid,
    output logic [AWIDTH-1:0] pc_out,
    output logic              redir_taken,
    output logic              busy
);

    ib_fetch_state_t   state;
    ib_fetch_state_t   nxt;
    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] inc;
    logic [AWIDTH-1:0] pc_sum;
    logic [AWIDTH-1:0] next_pc;
    logic              accept;

    assign accept   = (state == IB_REQ) && mem_ack;
    assign inc      = branch_en ? branch_off : AWIDTH'(IB_INC_ONE);
    assign next_pc  = jump_en ? jump_addr : pc_sum;
    assign mem_addr = pc;
    assign pc_out   = pc;

    ib_pc_adder #(.AWIDTH(AWIDTH)) u_adder (
        .pc  (pc),
        .inc (inc),
        .sum (pc_sum)
    );

    always_comb begin
        nxt = state;
        case (state)
            IB_IDLE, IB_HALTED: if (start) nxt = stall ? IB_STALL : IB_REQ;
            // halt outranks stall on the accept cycle
            IB_REQ:             if (mem_ack) nxt = halt ? IB_HALTED : (stall ? IB_STALL : IB_REQ);
            IB_STALL:           if (!stall) nxt = IB_REQ;
            default:            nxt = IB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IB_IDLE;
            pc          <= '0;
            mem_req     <= 1'b0;
            busy        <= 1'b0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            redir_taken <= 1'b0;
        end else begin
            state       <= nxt;
            mem_req     <= (nxt == IB_REQ);
            busy        <= (nxt == IB_REQ) || (nxt == IB_STALL);
            instr_valid <= accept;
            redir_taken <= accept && (jump_en || branch_en);
            if (accept) begin
                instr_out <= instr_in;
                pc        <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_ib_fetch_ctrl.sv
// Self-checking bench for ib_fetch_ctrl: directed scenarios then random
// traffic, all compared against a cycle-level behavioural model.
module tb_ib_fetch_ctrl;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int MOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stall, halt, branch_en, jump_en, mem_ack;
    logic [AW-1:0] branch_off, jump_addr;
    logic [DW-1:0] instr_in;
    logic          mem_req, instr_valid, redir_taken, busy;
    logic [AW-1:0] mem_addr, pc_out;
    logic [DW-1:0] instr_out;

    int n_checks = 0;
    int n_fail   = 0;

    // model: "fetching" and "stalled" flags; idle and halted behave alike
    bit            m_fetching, m_stalled, m_valid, m_redir;
    int            m_pc;
    logic [DW-1:0] m_instr;

    ib_fetch_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stall      (stall),
        .halt       (halt),
        .branch_en  (branch_en),
        .branch_off (branch_off),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .instr_in   (instr_in),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .pc_out     (pc_out),
        .redir_taken(redir_taken),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fetching = 0;
        m_stalled  = 0;
        m_valid    = 0;
        m_redir    = 0;
        m_pc       = 0;
        m_instr    = '0;
    endtask

    task automatic model_edge();
        int t;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_valid = 0;
            m_redir = 0;
            if (m_fetching) begin
                if (mem_ack) begin
                    m_instr = instr_in;
                    m_valid = 1;
                    m_redir = jump_en || branch_en;
                    if (jump_en)        m_pc = int'(jump_addr);
                    else if (branch_en) begin
                        t    = m_pc + int'($signed(branch_off));
                        m_pc = ((t % MOD) + MOD) % MOD;
                    end else            m_pc = (m_pc + 1) % MOD;
                    m_fetching = !halt && !stall;
                    m_stalled  = !halt && stall;
                end
            end else if (m_stalled) begin
                if (!stall) begin
                    m_stalled  = 0;
                    m_fetching = 1;
                end
            end else if (start) begin
                m_stalled  = stall;
                m_fetching = !stall;
            end
        end
    endtask

    task automatic compare_all();
        check("mem_req",     64'(mem_req),     64'(m_fetching));
        check("mem_addr",    64'(mem_addr),    64'(m_pc));
        check("pc_out",      64'(pc_out),      64'(m_pc));
        check("instr_out",   64'(instr_out),   64'(m_instr));
        check("instr_valid", 64'(instr_valid), 64'(m_valid));
        check("redir_taken", 64'(redir_taken), 64'(m_redir));
        check("busy",        64'(busy),        64'(m_fetching || m_stalled));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        start = 0; stall = 0; halt = 0; branch_en = 0; jump_en = 0;
        mem_ack = 0; branch_off = '0; jump_addr = '0; instr_in = DW'($urandom);
    endtask

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        model_reset();
        #1 rst_n = 1'b0;
        #1 compare_all();
        cycle();
        rst_n = 1'b1;

        // stream with ack tied high
        start = 1; mem_ack = 1;
        cycle();
        check("stream_addr0", 64'(mem_addr), 64'd0);
        start = 0;
        for (int k = 1; k <= 3; k++) begin
            instr_in = DW'($urandom);
            cycle();
            check("stream_valid", 64'(instr_valid), 64'd1);
            check("stream_addr",  64'(mem_addr),    64'(k));
        end

        // wrap through the top of the address space
        jump_en = 1; jump_addr = AW'(62); instr_in = DW'($urandom);
        cycle();
        check("wrap_62", 64'(mem_addr), 64'd62);
        jump_en = 0;
        cycle();
        check("wrap_63", 64'(mem_addr), 64'd63);
        cycle();
        check("wrap_0", 64'(mem_addr), 64'd0);

        // backward branch and jump priority
        jump_en = 1; jump_addr = AW'(10);
        cycle();
        jump_en = 0; branch_en = 1; branch_off = AW'(-4);
        cycle();
        check("branch_pc",    64'(pc_out),      64'd6);
        check("branch_redir", 64'(redir_taken), 64'd1);
        jump_en = 1; jump_addr = AW'(20); branch_off = AW'(5);
        cycle();
        check("jump_wins", 64'(pc_out), 64'd20);

        // wait states with stall toggling, then halt+stall on accept
        jump_en = 0; branch_en = 0; mem_ack = 0;
        for (int k = 0; k < 3; k++) begin
            stall = k[0];
            cycle();
            check("wait_req",  64'(mem_req),  64'd1);
            check("wait_addr", 64'(mem_addr), 64'd20);
        end
        mem_ack = 1; halt = 1; stall = 1;
        cycle();
        check("halt_busy", 64'(busy),    64'd0);
        check("halt_req",  64'(mem_req), 64'd0);
        check("halt_pc",   64'(pc_out),  64'd21);
        clear_inputs();
        cycle();

        // reset in the middle of an outstanding fetch
        start = 1;
        cycle();
        start = 0;
        check("pre_rst_req", 64'(mem_req), 64'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        check("rst_req", 64'(mem_req), 64'd0);
        cycle();
        rst_n = 1'b1; mem_ack = 1;
        cycle();
        check("late_ack_valid", 64'(instr_valid), 64'd0);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            start      = ($urandom_range(0, 9) < 3);
            stall      = ($urandom_range(0, 3) == 0);
            halt       = ($urandom_range(0, 19) == 0);
            mem_ack    = ($urandom_range(0, 9) < 6);
            branch_en  = ($urandom_range(0, 4) == 0);
            jump_en    = ($urandom_range(0, 9) == 0);
            branch_off = AW'($urandom);
            jump_addr  = AW'($urandom);
            instr_in   = DW'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
